// File: rtl/icache_axi_refill.sv
// -----------------------------------------------------------------------------
// icache_axi_refill
//   Instruction-cache refill engine. Accepts a refill request from the icache,
//   issues a single AXI read (8-beat line burst when cached, single beat when
//   uncached), assembles the returned beats into a 256-bit line and pulses
//   rend_o once the burst has finished.
//
// Optional feature (macro ICACHE_CRITICAL_WORD_FIRST_EN):
//   defined     -> cached bursts are WRAP bursts starting at the requested word
//   not defined -> cached bursts are INCR bursts starting at word 0 of the line
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   rreq_i                refill request, held until rend_o
//   cached_i              1 = line burst, 0 = single-word read
//   raddr_i               word-aligned fetch address
//   rend_o                one-cycle completion pulse
//   cacheline_rdata_o     assembled line, word i at [32i+31:32i]
//   busy_o                engine not idle
//   rerr_o                sticky error (any non-OKAY beat of current request)
//   ar*                   AXI read-address channel (master side)
//   r*                    AXI read-data channel (master side)
//
// Handshake: a transfer on a channel happens in a cycle where both valid and
//   ready are high at posedge clk; arvalid_o is held (with stable payload)
//   until arready_i, and rready_o stays high for the whole data phase.
// -----------------------------------------------------------------------------
module icache_axi_refill (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rreq_i,
  input  logic         cached_i,
  input  logic [31:0]  raddr_i,
  output logic         rend_o,
  output logic [255:0] cacheline_rdata_o,
  output logic         busy_o,
  output logic         rerr_o,
  output logic [3:0]   arid_o,
  output logic [31:0]  araddr_o,
  output logic [7:0]   arlen_o,
  output logic [2:0]   arsize_o,
  output logic [1:0]   arburst_o,
  output logic         arvalid_o,
  input  logic         arready_i,
  input  logic [3:0]   rid_i,
  input  logic [31:0]  rdata_i,
  input  logic [1:0]   rresp_i,
  input  logic         rlast_i,
  input  logic         rvalid_i,
  output logic         rready_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [31:0]    araddr_q, araddr_d;
  logic [7:0]     arlen_q, arlen_d;
  logic [1:0]     arburst_q, arburst_d;
  logic [2:0]     start_q, start_d;
  logic [2:0]     ptr_q, ptr_d;
  logic [255:0]   line_q, line_d;
  logic           rerr_q, rerr_d;

  logic           ar_hs;
  logic           r_hs;
  logic           req_accept;

  // Read ID is not needed: only one transaction is ever outstanding.
  logic           unused_rid;
  assign unused_rid = ^rid_i;

  assign ar_hs      = arvalid_o & arready_i;
  assign r_hs       = rvalid_i & rready_o;
  assign req_accept = (state_q == S_IDLE) & rreq_i;

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arburst_q <= '0;
      start_q   <= '0;
      ptr_q     <= '0;
      line_q    <= '0;
      rerr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      arburst_q <= arburst_d;
      start_q   <= start_d;
      ptr_q     <= ptr_d;
      line_q    <= line_d;
      rerr_q    <= rerr_d;
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (rreq_i)          state_d = S_AR;
      S_AR:   if (ar_hs)           state_d = S_R;
      S_R:    if (r_hs && rlast_i) state_d = S_DONE;
      S_DONE:                      state_d = S_IDLE;
      default:                     state_d = S_IDLE;
    endcase
  end

  // ----------------------------------------------------------------- datapath
  always_comb begin
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    arburst_d = arburst_q;
    start_d   = start_q;
    ptr_d     = ptr_q;
    line_d    = line_q;
    rerr_d    = rerr_q;

    // Request is captured once; the AR payload then stays frozen until the
    // next accepted request, so it is trivially stable while arvalid_o is up.
    if (req_accept) begin
      rerr_d    = 1'b0;
      arburst_d = 2'b01;
      if (cached_i) begin
        arlen_d = 8'd7;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
        araddr_d  = {raddr_i[31:2], 2'b00};
        arburst_d = 2'b10;
        start_d   = raddr_i[4:2];
`else
        araddr_d  = {raddr_i[31:5], 5'b0};
        start_d   = 3'd0;
`endif
      end else begin
        araddr_d = raddr_i;
        arlen_d  = 8'd0;
        start_d  = raddr_i[4:2];
      end
    end

    if (ar_hs) begin
      ptr_d = start_q;
    end

    // Pointer wraps naturally at 3 bits, so WRAP bursts and overlong bursts
    // both land in the right word without extra logic.
    if (r_hs) begin
      line_d[{ptr_q, 5'b0} +: 32] = rdata_i;
      ptr_d                       = ptr_q + 3'd1;
      if (rresp_i != 2'b00) begin
        rerr_d = 1'b1;
      end
    end
  end

  // ------------------------------------------------------------------ outputs
  always_comb begin
    arvalid_o = (state_q == S_AR);
    rready_o  = (state_q == S_R);
    rend_o    = (state_q == S_DONE);
    busy_o    = (state_q != S_IDLE);
  end

  assign arid_o            = 4'h0;
  assign arsize_o          = 3'b010;
  assign araddr_o          = araddr_q;
  assign arlen_o           = arlen_q;
  assign arburst_o         = arburst_q;
  assign cacheline_rdata_o = line_q;
  assign rerr_o            = rerr_q;

endmodule

// File: tb/tb_icache_axi_refill.sv
module tb_icache_axi_refill;

  // ------------------------------------------------------------ clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         rreq_i = 1'b0;
  logic         cached_i = 1'b0;
  logic [31:0]  raddr_i = '0;
  logic         rend_o;
  logic [255:0] cacheline_rdata_o;
  logic         busy_o;
  logic         rerr_o;
  logic [3:0]   arid_o;
  logic [31:0]  araddr_o;
  logic [7:0]   arlen_o;
  logic [2:0]   arsize_o;
  logic [1:0]   arburst_o;
  logic         arvalid_o;
  logic         arready_i = 1'b0;
  logic [3:0]   rid_i = '0;
  logic [31:0]  rdata_i = '0;
  logic [1:0]   rresp_i = '0;
  logic         rlast_i = 1'b0;
  logic         rvalid_i = 1'b0;
  logic         rready_o;

  icache_axi_refill dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .rreq_i            (rreq_i),
    .cached_i          (cached_i),
    .raddr_i           (raddr_i),
    .rend_o            (rend_o),
    .cacheline_rdata_o (cacheline_rdata_o),
    .busy_o            (busy_o),
    .rerr_o            (rerr_o),
    .arid_o            (arid_o),
    .araddr_o          (araddr_o),
    .arlen_o           (arlen_o),
    .arsize_o          (arsize_o),
    .arburst_o         (arburst_o),
    .arvalid_o         (arvalid_o),
    .arready_i         (arready_i),
    .rid_i             (rid_i),
    .rdata_i           (rdata_i),
    .rresp_i           (rresp_i),
    .rlast_i           (rlast_i),
    .rvalid_i          (rvalid_i),
    .rready_o          (rready_o)
  );

  // ------------------------------------------------------- scoreboard / model
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0]  exp_q[$];       // expected AR addresses, one per request
  logic [255:0] exp_line = '0;  // model of the line buffer
  logic         exp_err  = 1'b0;

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Address / length / burst / first word implied by a request.
  function automatic logic [31:0] model_araddr(input bit c, input logic [31:0] a);
    if (!c) return a;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    return a & 32'hFFFF_FFFC;
`else
    return a & 32'hFFFF_FFE0;
`endif
  endfunction

  function automatic int model_start(input bit c, input logic [31:0] a);
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    return int'((a >> 2) % 8);
`else
    return c ? 0 : int'((a >> 2) % 8);
`endif
  endfunction

  function automatic logic [1:0] model_burst(input bit c);
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    return c ? 2'b10 : 2'b01;
`else
    return 2'b01;
`endif
  endfunction

  // Outputs are sampled 1 time unit after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ------------------------------------------------------------------ driver
  // err_beat: -1 = random responses, otherwise only that beat answers SLVERR.
  // abort_beat: beat index at which reset is asserted (-1 = never).
  task automatic do_req(input bit c, input logic [31:0] a, input int nbeats,
                        input int ar_delay, input int max_gap, input int err_beat,
                        input bit keep, input int abort_beat,
                        input bit rnd_data, input logic [31:0] base);
    logic [31:0] exp_addr;
    int          start;
    logic [31:0] d;
    logic [1:0]  resp;
    rreq_i   = 1'b1;
    cached_i = c;
    raddr_i  = a;
    exp_q.push_back(model_araddr(c, a));
    start    = model_start(c, a);
    tick();
    exp_addr = exp_q.pop_front();
    exp_err  = 1'b0;
    check("ar_valid", 256'(arvalid_o), 256'(1'b1));
    check("ar_busy", 256'(busy_o), 256'(1'b1));
    check("rerr_clear", 256'(rerr_o), 256'(1'b0));
    check("araddr", 256'(araddr_o), 256'(exp_addr));
    check("arlen", 256'(arlen_o), c ? 256'(8'd7) : 256'(8'd0));
    check("arburst", 256'(arburst_o), 256'(model_burst(c)));
    check("arid", 256'(arid_o), 256'(4'h0));
    check("arsize", 256'(arsize_o), 256'(3'b010));
    // Inputs change after capture; the request must not follow them.
    raddr_i  = $urandom & 32'hFFFF_FFFC;
    cached_i = 1'($urandom_range(0, 1));
    for (int k = 0; k < ar_delay; k++) begin
      rvalid_i = 1'($urandom_range(0, 1));
      rdata_i  = $urandom;
      rresp_i  = 2'($urandom_range(0, 3));
      rlast_i  = 1'($urandom_range(0, 1));
      tick();
      check("ar_hold_valid", 256'(arvalid_o), 256'(1'b1));
      check("ar_hold_addr", 256'(araddr_o), 256'(exp_addr));
      check("ar_hold_rready", 256'(rready_o), 256'(1'b0));
    end
    rvalid_i  = 1'b0;
    rlast_i   = 1'b0;
    rresp_i   = 2'b00;
    arready_i = 1'b1;
    tick();
    arready_i = 1'b0;
    check("r_arvalid_low", 256'(arvalid_o), 256'(1'b0));
    check("r_rready", 256'(rready_o), 256'(1'b1));
    for (int i = 0; i < nbeats; i++) begin
      if (i == abort_beat) begin
        #2 rst_n = 1'b0;
        #1;
        exp_line = '0;
        exp_err  = 1'b0;
        check("rst_arvalid", 256'(arvalid_o), 256'(1'b0));
        check("rst_rready", 256'(rready_o), 256'(1'b0));
        check("rst_busy", 256'(busy_o), 256'(1'b0));
        check("rst_line", cacheline_rdata_o, 256'(0));
        check("rst_rend", 256'(rend_o), 256'(1'b0));
        check("rst_rerr", 256'(rerr_o), 256'(1'b0));
        check("rst_araddr", 256'(araddr_o), 256'(0));
        rreq_i   = 1'b0;
        rvalid_i = 1'b0;
        return;
      end
      repeat ($urandom_range(0, max_gap)) begin
        rvalid_i = 1'b0;
        tick();
        check("gap_rready", 256'(rready_o), 256'(1'b1));
        check("gap_rend", 256'(rend_o), 256'(1'b0));
      end
      d    = rnd_data ? $urandom : base + 32'(i);
      if (err_beat < 0) resp = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      else              resp = (i == err_beat) ? 2'b10 : 2'b00;
      rvalid_i = 1'b1;
      rdata_i  = d;
      rresp_i  = resp;
      rlast_i  = (i == nbeats - 1);
      tick();
      exp_line[((start + i) % 8) * 32 +: 32] = d;
      if (resp != 2'b00) exp_err = 1'b1;
      if (i != nbeats - 1) begin
        check("beat_rerr", 256'(rerr_o), 256'(exp_err));
        check("beat_rend", 256'(rend_o), 256'(1'b0));
      end
    end
    rvalid_i = 1'b0;
    rlast_i  = 1'b0;
    rresp_i  = 2'b00;
    check("done_rend", 256'(rend_o), 256'(1'b1));
    check("done_busy", 256'(busy_o), 256'(1'b1));
    check("done_rready", 256'(rready_o), 256'(1'b0));
    check("done_line", cacheline_rdata_o, exp_line);
    check("done_rerr", 256'(rerr_o), 256'(exp_err));
    if (!keep) rreq_i = 1'b0;
    rvalid_i = 1'($urandom_range(0, 1));
    rdata_i  = $urandom;
    rlast_i  = 1'b1;
    tick();
    rvalid_i = 1'b0;
    rlast_i  = 1'b0;
    check("idle_rend", 256'(rend_o), 256'(1'b0));
    check("idle_busy", 256'(busy_o), 256'(1'b0));
    check("idle_line", cacheline_rdata_o, exp_line);
    check("idle_rerr", 256'(rerr_o), 256'(exp_err));
  endtask

  // -------------------------------------------------------------- stimulus
  initial begin
    logic [255:0] snap;
    #1;
    check("reset_busy", 256'(busy_o), 256'(1'b0));
    check("reset_line", cacheline_rdata_o, 256'(0));
    check("reset_arvalid", 256'(arvalid_o), 256'(1'b0));
    check("reset_arlen", 256'(arlen_o), 256'(0));
    check("reset_arburst", 256'(arburst_o), 256'(0));
    check("reset_rerr", 256'(rerr_o), 256'(1'b0));
    repeat (3) tick();
    #2 rst_n = 1'b1;
    tick();

    // Directed cached line, arready after 2 cycles, data 0xA0..0xA7.
    do_req(1'b1, 32'h1FC0_0034, 8, 2, 0, 99, 1'b0, -1, 1'b0, 32'hA0);
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    snap = cacheline_rdata_o;
    check("cwf_word5", 256'(snap[5*32 +: 32]), 256'(32'hA0));
    check("cwf_word0", 256'(snap[0 +: 32]), 256'(32'hA3));
`else
    snap = cacheline_rdata_o;
    check("incr_word0", 256'(snap[0 +: 32]), 256'(32'hA0));
    check("incr_word7", 256'(snap[7*32 +: 32]), 256'(32'hA7));
`endif

    // Uncached single word into word 2.
    do_req(1'b0, 32'hBFC0_0008, 1, 1, 0, 99, 1'b0, -1, 1'b0, 32'hDEAD_BEEF);

    // Gapped cached burst with an error on beat 3.
    do_req(1'b1, 32'h0000_1040, 8, 0, 1, 3, 1'b0, -1, 1'b1, 32'h0);

    // Reset at beat 4, then a normal request.
    do_req(1'b1, 32'h0000_2000, 8, 1, 0, 99, 1'b0, 4, 1'b1, 32'h0);
    #3;
    tick();
    #2 rst_n = 1'b1;
    tick();
    do_req(1'b1, 32'h0000_3010, 8, 0, 0, 99, 1'b0, -1, 1'b1, 32'h0);

    // Back-to-back with rreq held, rvalid noise during AR.
    do_req(1'b1, 32'h0000_4004, 8, 3, 0, 99, 1'b1, -1, 1'b1, 32'h0);
    do_req(1'b0, 32'h0000_500C, 1, 3, 0, 99, 1'b0, -1, 1'b1, 32'h0);

    // Randomized requests: early rlast, overlong bursts, gaps, errors.
    for (int t = 0; t < 30; t++) begin
      bit c;
      c = 1'($urandom_range(0, 1));
      do_req(c, $urandom & 32'hFFFF_FFFC,
             c ? $urandom_range(1, 11) : $urandom_range(1, 2),
             $urandom_range(0, 3), $urandom_range(0, 2), -1,
             1'($urandom_range(0, 1)), -1, 1'b1, 32'h0);
    end
    rreq_i = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
